// File: rtl/pc_fetch16.sv
// Program counter and instruction-fetch request stage for the Hack CPU.
// It holds the fetch address steady through memory stalls and queues one late jump target.
module pc_fetch16 #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clear,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             pending
);

    // state | meaning
    // IDLE  | first cycle after reset, no fetch request, inputs ignored
    // RUN   | fetch request live on out, no jump queued
    // HOLD  | fetch request live, jump target captured during a stall
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_ADDR;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            tgt   <= tgt_nxt;
        end
    end

    assign xfer = (state != IDLE) && ready;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        tgt_nxt   = tgt;
        unique case (state)
            IDLE: state_nxt = RUN;
            RUN, HOLD: begin
                if (clear) begin
                    // Only path allowed to move the address during a stall.
                    pc_nxt    = RESET_ADDR;
                    tgt_nxt   = '0;
                    state_nxt = RUN;
                end else if (xfer) begin
                    if (load) begin
                        pc_nxt    = in;
                        state_nxt = RUN;
                    end else if (state == HOLD) begin
                        pc_nxt    = tgt;
                        state_nxt = RUN;
                    end else if (inc) begin
                        pc_nxt = pc + WIDTH'(1);
                    end
                end else if (load) begin
                    tgt_nxt   = in;
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out     = pc;
    assign valid   = (state == RUN) || (state == HOLD);
    assign pending = (state == HOLD);

endmodule

// File: tb/tb_pc_fetch16.sv
// Directed bench for pc_fetch16: a vector table for the steady-state behaviour,
// plus hand sequences for asynchronous reset and the IDLE cycle.
module tb_pc_fetch16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0, inc = 1'b0, clear = 1'b0, ready = 1'b0;
    logic [15:0] out;
    logic        valid, pending;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch16 #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load), .inc(inc),
        .clear(clear), .ready(ready), .out(out), .valid(valid), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        inc;
        logic        clear;
        logic        ready;
        logic [15:0] in;
        logic [15:0] exp_out;
        logic        exp_valid;
        logic        exp_pending;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out,
                             input logic e_valid, input logic e_pending);
        check({tag, " out"}, out, e_out);
        check({tag, " valid"}, {15'd0, valid}, {15'd0, e_valid});
        check({tag, " pending"}, {15'd0, pending}, {15'd0, e_pending});
    endtask

    task automatic add(input logic l, input logic i, input logic c, input logic r,
                       input logic [15:0] d, input logic [15:0] eo,
                       input logic ev, input logic ep);
        vec_t v;
        v.load = l; v.inc = i; v.clear = c; v.ready = r; v.in = d;
        v.exp_out = eo; v.exp_valid = ev; v.exp_pending = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic l, input logic i, input logic c, input logic r,
                         input logic [15:0] d);
        load = l; inc = i; clear = c; ready = r; in = d;
    endtask

    initial begin
        //   load inc clr rdy in        out      v  p
        add(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0); // IDLE -> RUN
        add(0, 1, 0, 1, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 0, 1, 16'h0000, 16'h0002, 1, 0);
        add(1, 0, 0, 1, 16'hFFFE, 16'hFFFE, 1, 0);
        add(0, 1, 0, 1, 16'h0000, 16'hFFFF, 1, 0);
        add(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0); // wrap
        add(0, 1, 0, 1, 16'h0000, 16'h0001, 1, 0);
        add(1, 0, 0, 1, 16'h0010, 16'h0010, 1, 0);
        add(1, 0, 0, 0, 16'h1234, 16'h0010, 1, 1); // stalled jump
        add(0, 0, 0, 0, 16'h0000, 16'h0010, 1, 1);
        add(1, 0, 0, 0, 16'h5678, 16'h0010, 1, 1); // overwrite target
        add(0, 1, 0, 0, 16'h0000, 16'h0010, 1, 1); // inc ignored in stall
        add(0, 1, 0, 1, 16'h0000, 16'h5678, 1, 0); // pending beats inc
        add(1, 0, 0, 1, 16'h0020, 16'h0020, 1, 0);
        add(1, 0, 0, 0, 16'h0ABC, 16'h0020, 1, 1);
        add(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0); // clear during stall
        add(1, 0, 0, 1, 16'h0100, 16'h0100, 1, 0);
        add(1, 1, 0, 1, 16'h0300, 16'h0300, 1, 0); // load beats inc
        add(1, 0, 1, 1, 16'h0555, 16'h0000, 1, 0); // clear beats load
        add(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0); // re-request
        add(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 0, 0, 1, 16'h0040, 16'h0040, 1, 0);
        add(1, 0, 0, 0, 16'h0777, 16'h0040, 1, 1);
        add(1, 0, 0, 1, 16'h0888, 16'h0888, 1, 0); // new load discards pending
        add(0, 1, 0, 1, 16'h0000, 16'h0889, 1, 0);

        #2;
        check_all("reset", 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 1, 16'h0000);
        #1 check_all("idle", 16'h0000, 0, 0);

        foreach (vecs[k]) begin
            if (k != 0) @(negedge clk);
            drive(vecs[k].load, vecs[k].inc, vecs[k].clear, vecs[k].ready, vecs[k].in);
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", k), vecs[k].exp_out,
                         vecs[k].exp_valid, vecs[k].exp_pending);
        end

        // Enter HOLD, then reset asynchronously between clock edges.
        @(negedge clk);
        drive(1, 0, 0, 1, 16'h0030);
        @(negedge clk);
        drive(1, 0, 0, 0, 16'h0ABC);
        @(posedge clk);
        #1 check_all("hold_pre_rst", 16'h0030, 1, 1);
        #1 rst_n = 1'b0;
        #1 check_all("async_rst", 16'h0000, 0, 0);

        // Release; load in IDLE must be ignored.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 16'h0999);
        #1 check_all("idle2", 16'h0000, 0, 0);
        @(posedge clk);
        #1 check_all("run_after_idle", 16'h0000, 1, 0);
        @(negedge clk);
        drive(0, 1, 0, 1, 16'h0000);
        @(posedge clk);
        #1 check_all("run_inc", 16'h0001, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
